// File: rtl/lnic_rx_pkt_buffer.sv
// Store-and-forward RX buffer: takes one word per valid cycle, shows a packet on out_* the cycle after its last word lands.
// No backpressure on net_in_*: a packet that will not fit is rewound and counted as a drop; out_* uses valid/ready.
module lnic_rx_pkt_buffer #(
  parameter int unsigned DEPTH  = 512,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              net_in_valid,
  input  logic [63:0]       net_in_bits_data,
  input  logic [7:0]        net_in_bits_keep,
  input  logic              net_in_bits_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_bits_data,
  output logic [7:0]        out_bits_keep,
  output logic              out_bits_last,
  output logic [15:0]       pkt_count,
  output logic [31:0]       drop_count,
  output logic [ADDR_W:0]   fill_level
);

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

  logic [72:0]     r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_commit_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [15:0]     r_pkt_count;
  logic [31:0]     r_drop_count;
  state_t          r_state;

  state_t          w_state_nxt;
  logic [ADDR_W:0] w_fill;
  logic            w_full;
  logic            w_wr_en;
  logic            w_commit;
  logic            w_rewind;
  logic            w_drop_inc;
  logic            w_rd;
  logic            w_rd_last;
  logic [72:0]     w_rd_word;

  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_fill == FULL_LVL);
  assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_rd      = out_valid && out_ready;
  assign w_rd_last = w_rd && w_rd_word[72];

  assign out_valid     = (r_rd_ptr != r_commit_ptr);
  assign out_bits_last = w_rd_word[72];
  assign out_bits_keep = w_rd_word[71:64];
  assign out_bits_data = w_rd_word[63:0];
  assign pkt_count     = r_pkt_count;
  assign drop_count    = r_drop_count;
  assign fill_level    = w_fill;

  // Full is judged on registered pointers, so a read this cycle frees space only for next cycle's write.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_drop_inc  = 1'b0;
    if (net_in_valid) begin
      case (r_state)
        ST_ACCEPT: begin
          if (!w_full) begin
            w_wr_en  = 1'b1;
            w_commit = net_in_bits_last;
          end else begin
            w_rewind = 1'b1;
            if (net_in_bits_last) w_drop_inc  = 1'b1;
            else                  w_state_nxt = ST_DROP;
          end
        end
        ST_DROP: begin
          if (net_in_bits_last) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = ST_ACCEPT;
          end
        end
        default: w_state_nxt = ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ACCEPT;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en)       r_wr_ptr <= r_wr_ptr + PTR_ONE;
      else if (w_rewind) r_wr_ptr <= r_commit_ptr;
      if (w_commit) r_commit_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd)     r_rd_ptr     <= r_rd_ptr + PTR_ONE;
      case ({w_commit, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + 16'd1;
        2'b01:   r_pkt_count <= r_pkt_count - 16'd1;
        default: r_pkt_count <= r_pkt_count;
      endcase
      if (w_drop_inc && (r_drop_count != 32'hFFFF_FFFF))
        r_drop_count <= r_drop_count + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {net_in_bits_last, net_in_bits_keep, net_in_bits_data};
  end

endmodule
